multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Sequencing controller for the multi-cycle variant of the MIPS datapath. It replaces the single-cycle combinational decoder with a Moore state machine. The machine steps each instruction through fetch, decode, execute, memory and write-back cycles, and drives every datapath mux select and write enable per cycle. It sits beside the shared instruction/data memory and stalls on a memory-ready handshake.

## Interface
Parameters:
- none (opcode encodings are fixed: R-type 6'd0, lw 6'd35, sw 6'd43, beq 6'd4, j 6'd2, addi 6'd8)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- opcode  input  6  instruction[31:26] from IR; valid from DECODE onward
- mem_ready  input  1  shared memory completes the current access this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by ALU zero (beq)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  destination: 0 = rt, 1 = rd
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  0 = PC, 1 = register A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALUOp  output  2  00 = add, 01 = subtract, 10 = funct field decides
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  opcode in DECODE is not one of the six supported
- state  output  4  current state encoding, for debug and verification

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Outputs are a function of state only, except the mem_ready gating noted below. Any output not listed for a state is 0.
- FETCH: MemRead=1, ALUSrcB=01, PCWrite=mem_ready, IRWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcB=11 (branch target into ALUOut). Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDIEX
  - any other opcode → FETCH, with illegal_op=1 for this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10. Goes to MEMRD for lw, MEMWR for sw (opcode re-examined).
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: IorD=1, MemWrite=mem_ready. Holds until mem_ready, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUOp=10. Goes to RWB.
- RWB: RegWrite=1, RegDst=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Goes to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0. Goes to FETCH.
- Unused encodings 12–15 go to FETCH on the next edge. All outputs are 0 while in them.

## Timing
- rst high: state goes to FETCH immediately, without waiting for a clock edge. PCWrite, IRWrite, RegWrite, MemWrite and PCWriteCond are forced to 0 while rst=1.
- After reset deasserts, outputs take FETCH values: MemRead=1, ALUSrcB=01, all others 0 apart from the mem_ready-gated enables.
- Reset asserted mid-instruction aborts the instruction. No write enable may be seen high during or after the reset edge.
- Cycle counts with mem_ready always 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3
  - illegal opcode 2, returning to FETCH
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs hold steady through the stall.
- IRWrite, PCWrite (in FETCH) and MemWrite (in MEMWR) are high only in the single cycle where mem_ready=1. This guarantees exactly one update per access.
- illegal_op is high for exactly one cycle per illegal instruction.

## Test plan
- Reset: assert rst asynchronously mid-cycle while in EXEC → state=0 before the next edge; RegWrite=0; after release MemRead=1, ALUSrcB=01.
- lw, mem_ready=1, opcode=35 → state sequence 0,1,2,3,4,0; MEMWB has RegWrite=1, MemtoReg=1, RegDst=0.
- sw with stall, opcode=43, mem_ready low for 2 cycles in MEMWR → sequence 0,1,2,5,5,5,0; MemWrite=1 only in the final MEMWR cycle.
- R-type and addi, opcode=0 then 8 → 0,1,6,7,0 with RegDst=1 in RWB; then 0,1,10,11,0 with ALUSrcB=10 in ADDIEX.
- beq and j, opcode=4 then 2 → 0,1,8,0 with PCWriteCond=1, PCSource=01, ALUOp=01; then 0,1,9,0 with PCWrite=1, PCSource=10.
- Illegal opcode, opcode=15 → 0,1,0; illegal_op=1 in the DECODE cycle only; no write enables asserted after FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore sequencing controller for the multi-cycle MIPS datapath: steps each
// instruction through fetch/decode/execute/memory/write-back and drives all selects.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic       is_fetch;
        logic       is_memwr;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // State-only part of the outputs; registered against the state being entered.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.is_fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWR:  begin c.is_memwr = 1'b1; c.iord = 1'b1; end
            S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01;
                c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
            end
            S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDIWB: c.reg_write = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t state_reg, state_next;
    ctrl_t  ctrl_reg;
    logic   op_legal;

    assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDIEX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_next = S_RWB;
            S_ADDIEX: state_next = S_ADDIWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
            ctrl_reg  <= ctrl_of(S_FETCH);
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_of(state_next);
        end
    end

    // Enables are gated by rst so nothing writes while reset is held.
    assign PCWrite     = !rst && (ctrl_reg.pc_write || (ctrl_reg.is_fetch && mem_ready));
    assign IRWrite     = !rst && ctrl_reg.is_fetch && mem_ready;
    assign MemWrite    = !rst && ctrl_reg.is_memwr && mem_ready;
    assign RegWrite    = !rst && ctrl_reg.reg_write;
    assign PCWriteCond = !rst && ctrl_reg.pc_write_cond;

    assign IorD       = ctrl_reg.iord;
    assign MemRead    = ctrl_reg.mem_read;
    assign MemtoReg   = ctrl_reg.mem_to_reg;
    assign RegDst     = ctrl_reg.reg_dst;
    assign ALUSrcA    = ctrl_reg.alu_src_a;
    assign ALUSrcB    = ctrl_reg.alu_src_b;
    assign ALUOp      = ctrl_reg.alu_op;
    assign PCSource   = ctrl_reg.pc_source;
    assign illegal_op = (state_reg == S_DECODE) && !op_legal;
    assign state      = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class and
// checks state sequence and per-state controls against hand-derived values.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'd0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_memread", MemRead, 1);
        @(posedge clk); #1; rst = 1'b0; #1;
        chk("fetch_irwrite", IRWrite, 1);
        chk("fetch_pcwrite", PCWrite, 1);
        chk("fetch_alusrcb", ALUSrcB, 1);

        // FETCH stall
        mem_ready = 1'b0; #1;
        chk("fstall_irwrite", IRWrite, 0);
        tick();
        chk("fstall_state", state, 0);
        chk("fstall_pcwrite", PCWrite, 0);
        chk("fstall_memread", MemRead, 1);
        mem_ready = 1'b1;

        // lw: 0,1,2,3,4,0
        opcode = 6'd35;
        tick(); chk("lw_s1", state, 1); chk("lw_dec_alusrcb", ALUSrcB, 3);
        chk("lw_dec_irwrite", IRWrite, 0);
        tick(); chk("lw_s2", state, 2); chk("lw_adr_alusrca", ALUSrcA, 1);
        chk("lw_adr_alusrcb", ALUSrcB, 2);
        tick(); chk("lw_s3", state, 3); chk("lw_rd_iord", IorD, 1);
        chk("lw_rd_memread", MemRead, 1);
        tick(); chk("lw_s4", state, 4); chk("lw_wb_regwrite", RegWrite, 1);
        chk("lw_wb_memtoreg", MemtoReg, 1); chk("lw_wb_regdst", RegDst, 0);
        tick(); chk("lw_s0", state, 0);

        // sw with two stall cycles in MEMWR: 0,1,2,5,5,5,0
        opcode = 6'd43;
        tick(); chk("sw_s1", state, 1);
        tick(); chk("sw_s2", state, 2);
        mem_ready = 1'b0;
        tick(); chk("sw_s5a", state, 5); chk("sw_memwrite_a", MemWrite, 0);
        chk("sw_iord_a", IorD, 1);
        tick(); chk("sw_s5b", state, 5); chk("sw_memwrite_b", MemWrite, 0);
        mem_ready = 1'b1; #1;
        chk("sw_s5c", state, 5); chk("sw_memwrite_c", MemWrite, 1);
        tick(); chk("sw_s0", state, 0); chk("sw_memwrite_after", MemWrite, 0);

        // R-type: 0,1,6,7,0
        opcode = 6'd0;
        tick(); chk("r_s1", state, 1);
        tick(); chk("r_s6", state, 6); chk("r_aluop", ALUOp, 2); chk("r_alusrca", ALUSrcA, 1);
        tick(); chk("r_s7", state, 7); chk("r_regdst", RegDst, 1); chk("r_regwrite", RegWrite, 1);
        tick(); chk("r_s0", state, 0);

        // addi: 0,1,10,11,0
        opcode = 6'd8;
        tick(); chk("addi_s1", state, 1);
        tick(); chk("addi_s10", state, 10); chk("addi_alusrcb", ALUSrcB, 2);
        tick(); chk("addi_s11", state, 11); chk("addi_regwrite", RegWrite, 1);
        chk("addi_regdst", RegDst, 0);
        tick(); chk("addi_s0", state, 0);

        // beq: 0,1,8,0
        opcode = 6'd4;
        tick(); chk("beq_s1", state, 1);
        tick(); chk("beq_s8", state, 8); chk("beq_pcwc", PCWriteCond, 1);
        chk("beq_pcsrc", PCSource, 1); chk("beq_aluop", ALUOp, 1); chk("beq_pcwrite", PCWrite, 0);
        tick(); chk("beq_s0", state, 0);

        // j: 0,1,9,0
        opcode = 6'd2;
        tick(); chk("j_s1", state, 1);
        tick(); chk("j_s9", state, 9); chk("j_pcwrite", PCWrite, 1); chk("j_pcsrc", PCSource, 2);
        tick(); chk("j_s0", state, 0);

        // illegal opcode: 0,1,0
        opcode = 6'd15;
        chk("ill_fetch_flag", illegal_op, 0);
        tick(); chk("ill_s1", state, 1); chk("ill_flag", illegal_op, 1);
        chk("ill_regwrite", RegWrite, 0); chk("ill_memwrite", MemWrite, 0);
        chk("ill_pcwrite", PCWrite, 0);
        tick(); chk("ill_s0", state, 0); chk("ill_flag_after", illegal_op, 0);

        // Async reset mid-EXEC
        opcode = 6'd0;
        tick(); tick(); chk("rx_s6", state, 6);
        #2 rst = 1'b1; #1;
        chk("rx_state", state, 0); chk("rx_regwrite", RegWrite, 0);
        @(posedge clk); #1; rst = 1'b0; #1;
        chk("rx_memread", MemRead, 1); chk("rx_alusrcb", ALUSrcB, 1);

        // Async reset during RWB must kill RegWrite immediately
        tick(); tick(); tick(); chk("rw_s7", state, 7); chk("rw_regwrite_pre", RegWrite, 1);
        #2 rst = 1'b1; #1;
        chk("rw_regwrite_rst", RegWrite, 0); chk("rw_state", state, 0);
        @(posedge clk); #1; rst = 1'b0; #1;
        chk("rw_post_state", state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
